// File: rtl/gray_step_monitor_if.sv
// rtl/gray_step_monitor_if.sv - sample/result bundle between a gray source and the step monitor
//
// Signals:
//   i_gray     gray code from the upstream counter (may be asynchronous)
//   i_clr      synchronous clear of o_pos / o_err_cnt
//   o_valid    tracking has started
//   o_bin      binary value of the last accepted sample
//   o_step_up  1-cycle pulse, +1 step
//   o_step_dn  1-cycle pulse, -1 step
//   o_err      1-cycle pulse, illegal jump
//   o_pos      signed up/down position (two's complement, wraps)
//   o_err_cnt  saturating illegal-jump count
// Modports:
//   master  drives i_gray/i_clr and observes the results
//   slave   the monitor itself
interface gray_step_monitor_if #(
  parameter int GRAY_W = 4,
  parameter int POS_W  = 16,
  parameter int ERR_W  = 8
);
  logic [GRAY_W-1:0] i_gray;
  logic              i_clr;
  logic              o_valid;
  logic [GRAY_W-1:0] o_bin;
  logic              o_step_up;
  logic              o_step_dn;
  logic              o_err;
  logic [POS_W-1:0]  o_pos;
  logic [ERR_W-1:0]  o_err_cnt;

  modport master (
    output i_gray, i_clr,
    input  o_valid, o_bin, o_step_up, o_step_dn, o_err, o_pos, o_err_cnt
  );

  modport slave (
    input  i_gray, i_clr,
    output o_valid, o_bin, o_step_up, o_step_dn, o_err, o_pos, o_err_cnt
  );
endinterface

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - gray counter step classifier with position and error tracking
//
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset, highest priority
//   bus     gray_step_monitor_if.slave (i_gray/i_clr in, results out)
// Parameters:
//   GRAY_W       width of gray input / binary output
//   POS_W        width of the signed position accumulator
//   ERR_W        width of the saturating illegal-jump counter
//   SYNC_STAGES  synchroniser depth on i_gray (2..4)
module gray_step_monitor #(
  parameter int GRAY_W      = 4,
  parameter int POS_W       = 16,
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  gray_step_monitor_if.slave   bus
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    S_INIT,
    S_TRACK
  } state_t;

  state_t            state_q;
  logic [FILL_W-1:0] fill_q;
  logic [GRAY_W-1:0] sync_q [SYNC_STAGES];
  logic [GRAY_W-1:0] prev_q;
  logic [GRAY_W-1:0] cur_bin;
  logic [GRAY_W-1:0] diff;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Only the last synchroniser stage is trusted as a settled sample.
  assign cur_bin = gray2bin(sync_q[SYNC_STAGES-1]);

  // Modular difference makes 15->0 a +1 and 0->15 a -1.
  assign diff = cur_bin - prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      state_q       <= S_INIT;
      fill_q        <= '0;
      prev_q        <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_bin     <= '0;
      bus.o_step_up <= 1'b0;
      bus.o_step_dn <= 1'b0;
      bus.o_err     <= 1'b0;
      bus.o_pos     <= '0;
      bus.o_err_cnt <= '0;
    end else begin
      sync_q[0] <= bus.i_gray;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end

      bus.o_step_up <= 1'b0;
      bus.o_step_dn <= 1'b0;
      bus.o_err     <= 1'b0;

      case (state_q)
        S_INIT: begin
          // Wait until the chain holds a real sample before adopting it as
          // the reference, so the first comparison never fires a pulse.
          if (fill_q == FILL_W'(SYNC_STAGES)) begin
            prev_q      <= cur_bin;
            bus.o_bin   <= cur_bin;
            bus.o_valid <= 1'b1;
            state_q     <= S_TRACK;
          end else begin
            fill_q <= fill_q + FILL_W'(1);
          end
        end

        S_TRACK: begin
          if (diff == GRAY_W'(1)) begin
            bus.o_step_up <= 1'b1;
            bus.o_pos     <= bus.o_pos + POS_W'(1);
            prev_q        <= cur_bin;
            bus.o_bin     <= cur_bin;
          end else if (diff == {GRAY_W{1'b1}}) begin
            bus.o_step_dn <= 1'b1;
            bus.o_pos     <= bus.o_pos - POS_W'(1);
            prev_q        <= cur_bin;
            bus.o_bin     <= cur_bin;
          end else if (diff != '0) begin
            // Illegal jump: count it and resynchronise to the new value so a
            // single glitch does not cascade into repeated errors.
            bus.o_err <= 1'b1;
            if (bus.o_err_cnt != {ERR_W{1'b1}}) begin
              bus.o_err_cnt <= bus.o_err_cnt + ERR_W'(1);
            end
            prev_q    <= cur_bin;
            bus.o_bin <= cur_bin;
          end
        end

        default: state_q <= S_INIT;
      endcase

      // Placed last so a clear overrides any same-cycle accumulator update;
      // the pulse itself is still emitted.
      if (bus.i_clr) begin
        bus.o_pos     <= '0;
        bus.o_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - scoreboard bench for gray_step_monitor
module tb_gray_step_monitor;
  localparam int GRAY_W      = 4;
  localparam int POS_W       = 16;
  localparam int ERR_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 1;

  localparam int K_UP  = 1;
  localparam int K_DN  = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int          kind;
    int          at;
    logic [3:0]  bin;
    logic [15:0] pos;
    logic [7:0]  ec;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  gray_step_monitor_if #(.GRAY_W(GRAY_W), .POS_W(POS_W), .ERR_W(ERR_W)) bus ();

  gray_step_monitor #(
    .GRAY_W(GRAY_W), .POS_W(POS_W), .ERR_W(ERR_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one gray value; if it should produce a pulse, queue the expected result.
  task automatic drive(input logic [3:0] g, input int kind, input logic [3:0] b,
                       input logic [15:0] p, input logic [7:0] e, input int hold);
    @(posedge i_clk); #1;
    bus.i_gray = g;
    if (kind != 0) sbq.push_back('{kind, cyc + LAT, b, p, e});
    repeat (hold - 1) @(posedge i_clk);
  endtask

  // Same as drive, with i_clr high exactly on the edge that registers the pulse.
  task automatic drive_clr(input logic [3:0] g, input int kind, input logic [3:0] b);
    @(posedge i_clk); #1;
    bus.i_gray = g;
    sbq.push_back('{kind, cyc + LAT, b, 16'h0000, 8'h00});
    repeat (LAT - 1) @(posedge i_clk);
    #1 bus.i_clr = 1'b1;
    @(posedge i_clk); #1 bus.i_clr = 1'b0;
    repeat (2) @(posedge i_clk);
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [3:0] b,
                               input logic [15:0] p, input logic [7:0] e);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'(v));
    chk({tag, "_bin"}, 32'(bus.o_bin), 32'(b));
    chk({tag, "_pos"}, 32'(bus.o_pos), 32'(p));
    chk({tag, "_errcnt"}, 32'(bus.o_err_cnt), 32'(e));
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin : monitor
    exp_t e;
    int   n_pulse;
    int   kind;
    n_pulse = int'(bus.o_step_up) + int'(bus.o_step_dn) + int'(bus.o_err);
    if (n_pulse != 0) begin
      chk("pulse_onehot", 32'(n_pulse), 32'd1);
      kind = bus.o_step_up ? K_UP : (bus.o_step_dn ? K_DN : K_ERR);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = sbq.pop_front();
        chk("pulse_kind", 32'(kind), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
        chk("pulse_bin", 32'(bus.o_bin), 32'(e.bin));
        chk("pulse_pos", 32'(bus.o_pos), 32'(e.pos));
        chk("pulse_errcnt", 32'(bus.o_err_cnt), 32'(e.ec));
      end
    end
  end

  initial begin
    bus.i_gray = 4'b0000;
    bus.i_clr  = 1'b0;
    i_rst      = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs("reset", 1'b0, 4'd0, 16'h0000, 8'h00);

    // Start-up: valid rises on the SYNC_STAGES+1-th edge after release.
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("init_valid_early", 32'(bus.o_valid), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs("init", 1'b1, 4'd0, 16'h0000, 8'h00);
    repeat (4) @(posedge i_clk);

    // Up steps 0->1->2->3.
    drive(4'b0001, K_UP, 4'd1, 16'd1, 8'd0, 5);
    drive(4'b0011, K_UP, 4'd2, 16'd2, 8'd0, 5);
    drive(4'b0010, K_UP, 4'd3, 16'd3, 8'd0, 5);
    // Back down to 0, then wrap 0->15 and back across the boundary.
    drive(4'b0011, K_DN, 4'd2, 16'd2, 8'd0, 5);
    drive(4'b0001, K_DN, 4'd1, 16'd1, 8'd0, 5);
    drive(4'b0000, K_DN, 4'd0, 16'd0, 8'd0, 5);
    drive(4'b1000, K_DN, 4'd15, 16'hFFFF, 8'd0, 5);
    drive(4'b0000, K_UP, 4'd0, 16'h0000, 8'd0, 5);
    drive(4'b1000, K_DN, 4'd15, 16'hFFFF, 8'd0, 5);
    drive(4'b0000, K_UP, 4'd0, 16'h0000, 8'd0, 5);

    // Illegal jump resynchronises; a following legal step is accepted.
    drive(4'b0110, K_ERR, 4'd4, 16'd0, 8'd1, 5);
    drive(4'b0111, K_UP, 4'd5, 16'd1, 8'd1, 5);
    drive(4'b0000, K_ERR, 4'd0, 16'd1, 8'd2, 3);
    for (int i = 0; i < 298; i++) begin
      if (i % 2 == 0) drive(4'b0110, K_ERR, 4'd4, 16'd1, 8'((3 + i > 255) ? 255 : 3 + i), 1);
      else            drive(4'b0000, K_ERR, 4'd0, 16'd1, 8'((3 + i > 255) ? 255 : 3 + i), 1);
    end
    repeat (6) @(posedge i_clk);
    @(negedge i_clk);
    chk("err_saturated", 32'(bus.o_err_cnt), 32'hFF);

    // Clear coincident with a step: pulse still emitted, counters cleared.
    drive_clr(4'b0001, K_UP, 4'd1);
    drive(4'b0011, K_UP, 4'd2, 16'd1, 8'd0, 5);
    drive(4'b0100, K_ERR, 4'd7, 16'd1, 8'd1, 5);

    // Reset mid-track, then re-entry with a non-zero input and no pulse.
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs("midrst", 1'b0, 4'd0, 16'h0000, 8'h00);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reentry_valid_early", 32'(bus.o_valid), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs("reentry", 1'b1, 4'd7, 16'h0000, 8'h00);
    repeat (5) @(posedge i_clk);
    drive(4'b0101, K_DN, 4'd6, 16'hFFFF, 8'd0, 5);

    repeat (10) @(posedge i_clk);
    chk("missing_pulses", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
